// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and defaults for the UART self-test controller
package bist_pkg;

  typedef enum logic [1:0] {
    READY,
    BIST_ACTIVE,
    BIST_LOOP,
    BIST_DONE
  } bist_state_t;

  localparam int DEF_NUM_PATTERNS   = 256;
  localparam int DEF_TIMEOUT_CYCLES = 1023;

  // Counter must hold TIMEOUT_CYCLES itself, never narrower than 10 bits.
  function automatic int ctr_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 10) ? 10 : w;
  endfunction

endpackage

// File: rtl/bist_timeout_ctr.sv
// rtl/bist_timeout_ctr.sv - receive-wait watchdog for the self-test loop
module bist_timeout_ctr
  import bist_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CW             = ctr_width(DEF_TIMEOUT_CYCLES)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CW'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the edge on which this increment makes the count reach TIMEOUT_CYCLES.
  assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bist_fsm.sv
// rtl/bist_fsm.sv - loopback self-test sequencer: sends byte k, checks the echo, flags errors
module bist_fsm
  import bist_pkg::*;
#(
  parameter int NUM_PATTERNS   = DEF_NUM_PATTERNS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       BIST_Start,
  input  logic       Data_Rdy,
  input  logic [7:0] Rx_Data_Out,
  output logic       BIST_Mode,
  output logic       BIST_Error,
  output logic [7:0] BIST_Tx_Data_Out,
  output logic       BIST_Tx_Start_Out,
  output logic       BIST_Busy
);

  localparam int CW = ctr_width(TIMEOUT_CYCLES);

  bist_state_t State, state_nxt;
  logic [8:0]  idx, idx_nxt;
  logic        err, err_nxt;
  logic        to_clear, to_en, to_expired;

  bist_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CW            (CW)
  ) u_timeout (
    .Clk    (Clk),
    .Rst    (Rst),
    .clear  (to_clear),
    .enable (to_en),
    .expired(to_expired)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      State <= READY;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      State <= state_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = State;
    idx_nxt   = idx;
    err_nxt   = err;
    to_clear  = 1'b0;
    to_en     = 1'b0;
    case (State)
      READY: begin
        if (BIST_Start) begin
          err_nxt   = 1'b0;
          idx_nxt   = '0;
          state_nxt = BIST_ACTIVE;
        end
      end
      BIST_ACTIVE: begin
        to_clear  = 1'b1;
        state_nxt = BIST_LOOP;
      end
      BIST_LOOP: begin
        if (Data_Rdy) begin
          // A mismatch is recorded but the sweep continues to the last pattern.
          if (Rx_Data_Out != idx[7:0]) begin
            err_nxt = 1'b1;
          end
          if (idx == 9'(NUM_PATTERNS - 1)) begin
            state_nxt = BIST_DONE;
          end else begin
            idx_nxt   = idx + 9'd1;
            state_nxt = BIST_ACTIVE;
          end
        end else begin
          to_en = 1'b1;
          if (to_expired) begin
            err_nxt   = 1'b1;
            state_nxt = BIST_DONE;
          end
        end
      end
      BIST_DONE: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = READY;
      end
    endcase
  end

  assign BIST_Mode         = (State == BIST_ACTIVE) || (State == BIST_LOOP);
  assign BIST_Busy         = (State != READY);
  assign BIST_Tx_Start_Out = (State == BIST_ACTIVE);
  assign BIST_Tx_Data_Out  = (State != READY) ? idx[7:0] : 8'h00;
  assign BIST_Error        = err;

endmodule

// File: tb/tb_bist_fsm.sv
// tb/tb_bist_fsm.sv - directed self-checking bench for bist_fsm (4 patterns, 8-cycle timeout)
module tb_bist_fsm;
  import bist_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       BIST_Start;
  logic       Data_Rdy;
  logic [7:0] Rx_Data_Out;
  logic       BIST_Mode;
  logic       BIST_Error;
  logic [7:0] BIST_Tx_Data_Out;
  logic       BIST_Tx_Start_Out;
  logic       BIST_Busy;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [3:0] visited = '0;

  always #5 Clk = ~Clk;

  bist_fsm #(
    .NUM_PATTERNS  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .BIST_Start       (BIST_Start),
    .Data_Rdy         (Data_Rdy),
    .Rx_Data_Out      (Rx_Data_Out),
    .BIST_Mode        (BIST_Mode),
    .BIST_Error       (BIST_Error),
    .BIST_Tx_Data_Out (BIST_Tx_Data_Out),
    .BIST_Tx_Start_Out(BIST_Tx_Start_Out),
    .BIST_Busy        (BIST_Busy)
  );

  always @(negedge Clk) visited[dut.State] = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_outs(input string tag, input bist_state_t st, input logic mode,
                             input logic busy, input logic txs, input logic [7:0] data,
                             input logic err);
    check({tag, ".state"}, 32'(dut.State), 32'(st));
    check({tag, ".mode"},  32'(BIST_Mode), 32'(mode));
    check({tag, ".busy"},  32'(BIST_Busy), 32'(busy));
    check({tag, ".txs"},   32'(BIST_Tx_Start_Out), 32'(txs));
    check({tag, ".data"},  32'(BIST_Tx_Data_Out), 32'(data));
    check({tag, ".err"},   32'(BIST_Error), 32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bist_state_t s;

    Rst = 1'b1; BIST_Start = 1'b0; Data_Rdy = 1'b0; Rx_Data_Out = 8'h00;
    repeat (2) @(negedge Clk);
    expect_outs("reset", READY, 0, 0, 0, 8'h00, 0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    expect_outs("idle", READY, 0, 0, 0, 8'h00, 0);

    // start and loopback pass
    BIST_Start = 1'b1;
    @(negedge Clk);
    expect_outs("start", BIST_ACTIVE, 1, 1, 1, 8'h00, 0);
    BIST_Start = 1'b0;
    @(negedge Clk);
    expect_outs("loop0", BIST_LOOP, 1, 1, 0, 8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      Data_Rdy = 1'b1; Rx_Data_Out = 8'(k);
      @(negedge Clk);
      Data_Rdy = 1'b0;
      if (k < 3) begin
        expect_outs($sformatf("pass_act%0d", k + 1), BIST_ACTIVE, 1, 1, 1, 8'(k + 1), 0);
        @(negedge Clk);
        expect_outs($sformatf("pass_loop%0d", k + 1), BIST_LOOP, 1, 1, 0, 8'(k + 1), 0);
      end else begin
        expect_outs("pass_done", BIST_DONE, 0, 1, 0, 8'h03, 0);
      end
    end
    @(negedge Clk);
    expect_outs("pass_ready", READY, 0, 0, 0, 8'h00, 0);

    // mismatch: Data_Rdy held with constant 0x00
    BIST_Start = 1'b1;
    @(negedge Clk);
    BIST_Start = 1'b0; Data_Rdy = 1'b1; Rx_Data_Out = 8'h00;
    @(negedge Clk);
    expect_outs("mm_loop0", BIST_LOOP, 1, 1, 0, 8'h00, 0);
    @(negedge Clk);
    expect_outs("mm_act1", BIST_ACTIVE, 1, 1, 1, 8'h01, 0);
    @(negedge Clk);
    @(negedge Clk);
    expect_outs("mm_act2", BIST_ACTIVE, 1, 1, 1, 8'h02, 1);
    n = 0;
    while (dut.State != READY && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("mm_reach_ready", 32'(n < 20), 32'(1));
    Data_Rdy = 1'b0;
    expect_outs("mm_ready", READY, 0, 0, 0, 8'h00, 1);
    repeat (2) @(negedge Clk);
    check("mm_sticky", 32'(BIST_Error), 32'(1));

    // timeout: no Data_Rdy ever
    BIST_Start = 1'b1;
    @(negedge Clk);
    expect_outs("to_start", BIST_ACTIVE, 1, 1, 1, 8'h00, 0);
    BIST_Start = 1'b0;
    @(negedge Clk);
    n = 0;
    while (dut.State == BIST_LOOP && n < 50) begin
      n++;
      @(negedge Clk);
    end
    check("to_loop_cycles", 32'(n), 32'(8));
    expect_outs("to_done", BIST_DONE, 0, 1, 0, 8'h00, 1);
    @(negedge Clk);
    expect_outs("to_ready", READY, 0, 0, 0, 8'h00, 1);

    // reset during BIST_LOOP with error already set
    BIST_Start = 1'b1; Data_Rdy = 1'b1; Rx_Data_Out = 8'hFF;
    @(negedge Clk);
    BIST_Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    expect_outs("rm_loop1", BIST_LOOP, 1, 1, 0, 8'h01, 1);
    Rst = 1'b1;
    #1;
    expect_outs("rm_reset", READY, 0, 0, 0, 8'h00, 0);
    Data_Rdy = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    s = s.first();
    for (int i = 0; i < s.num(); i++) begin
      check({"visit_", s.name()}, 32'(visited[s]), 32'(1));
      s = s.next();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bist_fsm.md
# bist_fsm

Built-in self-test controller for the UART. On request it puts the UART into loopback mode and transmits a sequence of byte patterns through the transmitter. Each byte received back is compared against the byte sent. It reports busy/done and a sticky error flag, and sits between the top-level control logic and the UART Tx/Rx datapaths.

## Interface
- NUM_PATTERNS, 256: number of bytes sent per test (1..256); pattern k is the byte value k (0x00, 0x01, ...).
- TIMEOUT_CYCLES, 1023: maximum cycles to wait in BIST_LOOP for Data_Rdy before declaring an error.

Ports:
- Clk  in  1  single system clock, rising-edge.
- Rst  in  1  reset, asynchronous, active-high.
- BIST_Start  in  1  test request, level-sampled in READY.
- Data_Rdy  in  1  receiver has a byte on Rx_Data_Out, level-sampled in BIST_LOOP.
- Rx_Data_Out  in  8  byte from the UART receiver.
- BIST_Mode  out  1  enables UART loopback.
- BIST_Error  out  1  sticky mismatch/timeout flag.
- BIST_Tx_Data_Out  out  8  byte to transmit.
- BIST_Tx_Start_Out  out  1  one-cycle transmit strobe.
- BIST_Busy  out  1  test in progress.

## Operation
- State register is named `State`, of enum type `bist_state_t`.
- `bist_state_t` values, in declaration order: READY, BIST_ACTIVE, BIST_LOOP, BIST_DONE. Verification iterates `.first`..`.last` over this order.
- Internal registers:
  - Pattern index `idx`, 9 bits.
  - Timeout counter, 10 bits minimum, sized from TIMEOUT_CYCLES.
- READY:
  - Idle.
  - If BIST_Start=1: clear BIST_Error, set idx=0, go to BIST_ACTIVE.
  - Otherwise stay in READY. BIST_Error holds its last value.
- BIST_ACTIVE (always exactly one cycle):
  - Drive BIST_Tx_Data_Out=idx[7:0] and BIST_Tx_Start_Out=1.
  - Clear the timeout counter.
  - Go to BIST_LOOP.
- BIST_LOOP:
  - If Data_Rdy=1: compare Rx_Data_Out with idx[7:0]; on mismatch set BIST_Error.
    - If idx==NUM_PATTERNS-1, go to BIST_DONE.
    - Otherwise idx++ and go to BIST_ACTIVE.
  - If Data_Rdy=0: increment the timeout counter. When it reaches TIMEOUT_CYCLES, set BIST_Error and go to BIST_DONE.
- BIST_DONE (always exactly one cycle): go to READY.
- BIST_Start is ignored outside READY. A start held high through BIST_DONE begins a new test one cycle after returning to READY.
- Outputs are Moore, decoded from State and registers:
  - BIST_Mode=1 in BIST_ACTIVE and BIST_LOOP.
  - BIST_Busy=1 in BIST_ACTIVE, BIST_LOOP and BIST_DONE.
  - BIST_Tx_Start_Out=1 only in BIST_ACTIVE.
  - BIST_Tx_Data_Out=idx[7:0] while busy, 0x00 in READY.
- Errors never abort the sequence, except a timeout.

## Timing
- Reset (asynchronous, any state): State=READY, idx=0, timeout counter=0, all outputs 0.
- Start latency: BIST_Start sampled high at edge N puts State in BIST_ACTIVE after edge N. BIST_Mode, BIST_Busy and BIST_Tx_Start_Out are high in cycle N+1.
- Per byte: one BIST_ACTIVE cycle plus one or more BIST_LOOP cycles.
- Data_Rdy and Rx_Data_Out are sampled on the same edge. A Data_Rdy still high on the first BIST_LOOP cycle after a transmit counts as the next byte; the receiver must pulse Data_Rdy for one cycle per byte.
- Minimum test length: 2*NUM_PATTERNS+1 cycles from BIST_ACTIVE entry to READY.
- Reset mid-test returns immediately to READY with BIST_Error=0.

## Structure
- Package `bist_pkg`: `bist_state_t` enum and default parameter constants.
- One natural sub-module, `bist_timeout_ctr`:
  - Inputs: clear and enable.
  - Output: expired flag.

## Test plan
- Reset: Rst=1 for 2 cycles -> State=READY, all outputs 0; after release with BIST_Start=0, State stays READY.
- Start: BIST_Start=1 at a negedge -> next cycle BIST_ACTIVE, BIST_Tx_Start_Out=1 for exactly one cycle, BIST_Tx_Data_Out=0x00, BIST_Mode=BIST_Busy=1; then BIST_LOOP.
- Loopback pass (NUM_PATTERNS=4): respond to each strobe with a one-cycle Data_Rdy and Rx_Data_Out equal to the byte sent -> bytes 0x00..0x03 sent, BIST_DONE visited, back to READY, BIST_Error=0.
- Mismatch: Data_Rdy held high with Rx_Data_Out=0x00 -> byte 0x00 passes; the next compare, against 0x01, sets BIST_Error=1; BIST_Error stays 1 through READY until the next BIST_Start.
- Timeout (TIMEOUT_CYCLES=8): never assert Data_Rdy -> BIST_Error=1 and BIST_DONE after 8 BIST_LOOP cycles.
- Coverage: across the scenarios above, all four states are visited; reset asserted during BIST_LOOP -> immediate READY with all outputs 0.
